// File: rtl/bht_restore.sv
// BHT checkpoint restore engine.
// Streams a packed branch-history-table image from memory through a single
// dcache load port, one 64-bit word at a time, and replays each word into the
// BHT as 16 entries of {valid, counter[1:0]}.

package bht_restore_pkg;

    // Request bundle towards the dcache load port
    typedef struct packed {
        logic [11:0] address_index;
        logic [43:0] address_tag;
        logic [63:0] data_wdata;
        logic        data_req;
        logic        data_we;
        logic [7:0]  data_be;
        logic [1:0]  data_size;
        logic        kill_req;
        logic        tag_valid;
    } dcache_req_i_t;

    // Response bundle from the dcache load port
    typedef struct packed {
        logic        data_gnt;
        logic        data_rvalid;
        logic [63:0] data_rdata;
    } dcache_req_o_t;

endpackage

module bht_restore
    import bht_restore_pkg::*;
#(
    parameter  int unsigned NR_ENTRIES       = 1024,
    parameter  int unsigned ENTRIES_PER_WORD = 16,
    localparam int unsigned NR_WORDS         = NR_ENTRIES / ENTRIES_PER_WORD,
    localparam int unsigned WORD_W           = (NR_WORDS > 1) ? $clog2(NR_WORDS) : 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                start_i,
    input  logic                flush_i,
    input  logic [63:0]         base_addr_i,
    output dcache_req_i_t       dcache_req_o,
    input  dcache_req_o_t       dcache_rsp_i,
    output logic                restore_valid_o,
    output logic [WORD_W-1:0]   restore_word_o,
    output logic [47:0]         restore_data_o,
    output logic                busy_o,
    output logic                done_o
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        TAG,
        WAIT,
        WRITE,
        DONE
    } state_e;

    state_e              state_q, state_d;
    logic [WORD_W-1:0]   counter_q;
    logic [60:0]         base_q;
    logic [47:0]         entries_q;
    logic [47:0]         entries_d;
    logic [60:0]         word_addr;
    logic [15:0]         unused_rdata_bits;
    logic                unused_ok;

    logic                load_start;
    logic                capture;
    logic                advance;

    // The word address wraps naturally inside 61 bits, giving mod 2^61 behaviour.
    assign word_addr = base_q + 61'(counter_q);

    // Upper address bits and per-entry spare bits carry no meaning here.
    assign unused_ok = ^{unused_rdata_bits, base_addr_i[2:0], word_addr[60:53]};

    // Compact the 4-bit memory slots into 3-bit BHT entries, dropping the spare bit.
    always_comb begin
        entries_d         = '0;
        unused_rdata_bits = '0;
        for (int k = 0; k < 16; k++) begin
            entries_d[3*k +: 3]  = dcache_rsp_i.data_rdata[4*k +: 3];
            unused_rdata_bits[k] = dcache_rsp_i.data_rdata[4*k+3];
        end
    end

    // State register plus the word counter, latched base and captured entries.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            counter_q <= '0;
            base_q    <= '0;
            entries_q <= '0;
        end else begin
            state_q <= state_d;
            if (load_start) begin
                counter_q <= '0;
                base_q    <= base_addr_i[63:3];
            end else if (advance) begin
                counter_q <= counter_q + 1'b1;
            end
            if (capture) begin
                entries_q <= entries_d;
            end
        end
    end

    // Next-state and output decode; flush wins over every handshake in REQ..WRITE.
    always_comb begin
        state_d                    = state_q;
        load_start                 = 1'b0;
        capture                    = 1'b0;
        advance                    = 1'b0;
        restore_valid_o            = 1'b0;
        done_o                     = 1'b0;
        busy_o                     = (state_q != IDLE);
        dcache_req_o               = '0;
        dcache_req_o.data_be       = 8'hFF;
        dcache_req_o.data_size     = 2'b11;
        dcache_req_o.address_index = {word_addr[8:0], 3'b000};
        dcache_req_o.address_tag   = word_addr[52:9];

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    load_start = 1'b1;
                    state_d    = REQ;
                end
            end
            REQ: begin
                if (flush_i) begin
                    dcache_req_o.kill_req = 1'b1;
                    state_d               = IDLE;
                end else begin
                    dcache_req_o.data_req = 1'b1;
                    if (dcache_rsp_i.data_gnt) begin
                        state_d = TAG;
                    end
                end
            end
            TAG: begin
                dcache_req_o.tag_valid = 1'b1;
                if (flush_i) begin
                    dcache_req_o.kill_req = 1'b1;
                    state_d               = IDLE;
                end else if (dcache_rsp_i.data_rvalid) begin
                    capture = 1'b1;
                    state_d = WRITE;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (flush_i) begin
                    dcache_req_o.kill_req = 1'b1;
                    state_d               = IDLE;
                end else if (dcache_rsp_i.data_rvalid) begin
                    capture = 1'b1;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                if (flush_i) begin
                    dcache_req_o.kill_req = 1'b1;
                    state_d               = IDLE;
                end else begin
                    restore_valid_o = 1'b1;
                    if (counter_q == WORD_W'(NR_WORDS - 1)) begin
                        state_d = DONE;
                    end else begin
                        advance = 1'b1;
                        state_d = REQ;
                    end
                end
            end
            DONE: begin
                done_o  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign restore_word_o = counter_q;
    assign restore_data_o = entries_q;

endmodule

// File: tb/tb_bht_restore.sv
// Directed testbench for bht_restore with a two-word image (NR_ENTRIES = 32).
// The bench plays the dcache by hand and checks every handshake and BHT write
// against hand-computed addresses and entry packings.

module tb_bht_restore;
    import bht_restore_pkg::*;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          flush;
    logic [63:0]   base_addr;
    dcache_req_i_t dcache_req;
    dcache_req_o_t dcache_rsp;
    logic          restore_valid;
    logic [0:0]    restore_word;
    logic [47:0]   restore_data;
    logic          busy;
    logic          done;

    int compareCount = 0;
    int failCount    = 0;

    bht_restore #(
        .NR_ENTRIES       (32),
        .ENTRIES_PER_WORD (16)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .start_i         (start),
        .flush_i         (flush),
        .base_addr_i     (base_addr),
        .dcache_req_o    (dcache_req),
        .dcache_rsp_i    (dcache_rsp),
        .restore_valid_o (restore_valid),
        .restore_word_o  (restore_word),
        .restore_data_o  (restore_data),
        .busy_o          (busy),
        .done_o          (done)
    );

    // Free-running 10-unit clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the directed sequence ever stalls
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compareCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Move to just after the next rising edge so inputs and checks sit between edges
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Pulse start for one cycle from IDLE; returns with the DUT in REQ
    task automatic startRestore(input logic [63:0] base);
        start     = 1'b1;
        base_addr = base;
        #1;
        checkOutput("idle_busy", 64'(busy), 64'd0);
        tick();
        start = 1'b0;
    endtask

    // One full load transaction from REQ through WRITE with configurable stalls
    task automatic applyStimulus(input int gntDelay, input int rvalidDelay, input logic [63:0] rdata,
                                 input logic [11:0] expIndex, input logic [43:0] expTag,
                                 input logic expWord, input logic [47:0] expData);
        for (int i = 0; i < gntDelay; i++) begin
            dcache_rsp.data_gnt = 1'b0;
            #1;
            checkOutput("stall_req", 64'(dcache_req.data_req), 64'd1);
            checkOutput("stall_index", 64'(dcache_req.address_index), 64'(expIndex));
            checkOutput("stall_tag_valid", 64'(dcache_req.tag_valid), 64'd0);
            tick();
        end
        dcache_rsp.data_gnt = 1'b1;
        #1;
        checkOutput("req_data_req", 64'(dcache_req.data_req), 64'd1);
        checkOutput("req_index", 64'(dcache_req.address_index), 64'(expIndex));
        checkOutput("req_we", 64'({dcache_req.data_we, dcache_req.data_be, dcache_req.data_size}), 64'h3FF);
        tick();
        dcache_rsp.data_gnt = 1'b0;
        for (int i = 0; i < rvalidDelay; i++) begin
            #1;
            checkOutput("wait_tag_valid", 64'(dcache_req.tag_valid), 64'(i == 0));
            checkOutput("wait_data_req", 64'(dcache_req.data_req), 64'd0);
            tick();
        end
        dcache_rsp.data_rvalid = 1'b1;
        dcache_rsp.data_rdata  = rdata;
        #1;
        checkOutput("tag_valid", 64'(dcache_req.tag_valid), 64'(rvalidDelay == 0));
        checkOutput("tag_addr", 64'(dcache_req.address_tag), 64'(expTag));
        tick();
        dcache_rsp.data_rvalid = 1'b0;
        dcache_rsp.data_rdata  = '0;
        #1;
        checkOutput("write_valid", 64'(restore_valid), 64'd1);
        checkOutput("write_word", 64'(restore_word), 64'(expWord));
        checkOutput("write_data", 64'(restore_data), 64'(expData));
        checkOutput("write_done", 64'(done), 64'd0);
        tick();
    endtask

    // Expect the completion pulse now and an idle engine one cycle later
    task automatic finishDone();
        #1;
        checkOutput("done_pulse", 64'(done), 64'd1);
        checkOutput("done_busy", 64'(busy), 64'd1);
        checkOutput("done_valid", 64'(restore_valid), 64'd0);
        tick();
        #1;
        checkOutput("after_done", 64'(done), 64'd0);
        checkOutput("after_busy", 64'(busy), 64'd0);
    endtask

    // Directed sequence covering reset, stalls, flush, busy start, reset abort and wrap
    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        flush      = 1'b0;
        base_addr  = '0;
        dcache_rsp = '0;
        repeat (2) @(posedge clk);
        #2;
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_done", 64'(done), 64'd0);
        checkOutput("rst_req", 64'(dcache_req.data_req), 64'd0);
        checkOutput("rst_tag_valid", 64'(dcache_req.tag_valid), 64'd0);
        checkOutput("rst_kill", 64'(dcache_req.kill_req), 64'd0);
        checkOutput("rst_valid", 64'(restore_valid), 64'd0);
        checkOutput("rst_data", 64'(restore_data), 64'd0);
        rst_n = 1'b1;
        tick();

        $display("[TB] full restore");
        startRestore(64'h8000_1000);
        applyStimulus(0, 0, 64'h0000_0000_0765_4321, 12'h000, 44'h80001, 1'b0, 48'o7654321);
        applyStimulus(0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 12'h008, 44'h80001, 1'b1, 48'hFFFF_FFFF_FFFF);
        finishDone();
        tick();

        $display("[TB] grant stall and late rvalid");
        startRestore(64'h0000_1230);
        applyStimulus(5, 0, 64'h8888_8888_8888_8888, 12'h230, 44'h1, 1'b0, 48'h0);
        applyStimulus(0, 2, 64'hAAAA_AAAA_AAAA_AAAA, 12'h238, 44'h1, 1'b1, 48'o2222222222222222);
        finishDone();
        tick();

        $display("[TB] flush during WAIT");
        startRestore(64'h8000_1000);
        dcache_rsp.data_gnt = 1'b1;
        tick();
        dcache_rsp.data_gnt = 1'b0;
        tick();
        flush = 1'b1;
        #1;
        checkOutput("flush_kill", 64'(dcache_req.kill_req), 64'd1);
        checkOutput("flush_valid", 64'(restore_valid), 64'd0);
        tick();
        flush = 1'b0;
        #1;
        checkOutput("flush_busy", 64'(busy), 64'd0);
        checkOutput("flush_kill_clear", 64'(dcache_req.kill_req), 64'd0);
        dcache_rsp.data_rvalid = 1'b1;
        dcache_rsp.data_rdata  = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        dcache_rsp.data_rvalid = 1'b0;
        dcache_rsp.data_rdata  = '0;
        #1;
        checkOutput("late_rvalid_valid", 64'(restore_valid), 64'd0);
        checkOutput("late_rvalid_busy", 64'(busy), 64'd0);
        checkOutput("late_rvalid_done", 64'(done), 64'd0);
        tick();
        startRestore(64'h8000_1000);
        applyStimulus(0, 0, 64'h1111_1111_1111_1111, 12'h000, 44'h80001, 1'b0, 48'o1111111111111111);
        applyStimulus(0, 1, 64'h0, 12'h008, 44'h80001, 1'b1, 48'h0);
        finishDone();
        tick();

        $display("[TB] flush beats grant in REQ");
        startRestore(64'h8000_1000);
        dcache_rsp.data_gnt = 1'b1;
        flush               = 1'b1;
        #1;
        checkOutput("flush_req_kill", 64'(dcache_req.kill_req), 64'd1);
        tick();
        dcache_rsp.data_gnt = 1'b0;
        flush               = 1'b0;
        #1;
        checkOutput("flush_req_busy", 64'(busy), 64'd0);
        checkOutput("flush_req_tag_valid", 64'(dcache_req.tag_valid), 64'd0);
        tick();

        $display("[TB] start while busy");
        startRestore(64'h2000_0040);
        start     = 1'b1;
        base_addr = 64'h9999_0000;
        #1;
        checkOutput("busy_start_index", 64'(dcache_req.address_index), 64'h040);
        tick();
        start = 1'b0;
        applyStimulus(0, 0, 64'h0, 12'h040, 44'h20000, 1'b0, 48'h0);
        applyStimulus(0, 1, 64'h3333_3333_3333_3333, 12'h048, 44'h20000, 1'b1, 48'o3333333333333333);
        finishDone();
        tick();

        $display("[TB] reset mid-restore");
        startRestore(64'h8000_1000);
        dcache_rsp.data_gnt = 1'b1;
        tick();
        dcache_rsp.data_gnt = 1'b0;
        #1;
        checkOutput("pre_rst_tag_valid", 64'(dcache_req.tag_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_tag_valid", 64'(dcache_req.tag_valid), 64'd0);
        checkOutput("mid_rst_busy", 64'(busy), 64'd0);
        checkOutput("mid_rst_req", 64'(dcache_req.data_req), 64'd0);
        checkOutput("mid_rst_tag", 64'(dcache_req.address_tag), 64'd0);
        tick();
        rst_n                  = 1'b1;
        dcache_rsp.data_rvalid = 1'b1;
        dcache_rsp.data_rdata  = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        dcache_rsp.data_rvalid = 1'b0;
        dcache_rsp.data_rdata  = '0;
        #1;
        checkOutput("post_rst_valid", 64'(restore_valid), 64'd0);
        checkOutput("post_rst_busy", 64'(busy), 64'd0);
        checkOutput("post_rst_done", 64'(done), 64'd0);
        tick();

        $display("[TB] address wrap and flush in DONE");
        startRestore(64'hFFFF_FFFF_FFFF_FFF8);
        applyStimulus(0, 0, 64'h1, 12'hFF8, 44'hFFF_FFFF_FFFF, 1'b0, 48'h1);
        applyStimulus(0, 0, 64'h2, 12'h000, 44'h0, 1'b1, 48'h2);
        flush = 1'b1;
        #1;
        checkOutput("done_flush_pulse", 64'(done), 64'd1);
        checkOutput("done_flush_kill", 64'(dcache_req.kill_req), 64'd0);
        tick();
        flush = 1'b0;
        #1;
        checkOutput("done_flush_busy", 64'(busy), 64'd0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule

// File: doc/bht_restore.md
BHT_RESTORE -- requirements
Module: bht_restore

Interface
REQ-001 SHALL have parameter NR_ENTRIES, default 1024, total BHT entries to restore; multiple of 16.
REQ-002 SHALL have parameter ENTRIES_PER_WORD, default 16, entries packed per 64-bit word; derived NR_WORDS = NR_ENTRIES/16.
REQ-003 SHALL use one clock and an asynchronous, active-low reset.
REQ-004 SHALL have port clk_i, input, 1, clock.
REQ-005 SHALL have port rst_ni, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port start_i, input, 1, single-cycle restore request.
REQ-007 SHALL have port flush_i, input, 1, abort of any restore in progress.
REQ-008 SHALL have port base_addr_i, input, 64, checkpoint image base address; bits [2:0] ignored.
REQ-009 SHALL have port dcache_req_o, output, dcache_req_i_t, load port request.
  - Fields driven: address_index, address_tag, data_req, tag_valid, kill_req, data_we, data_be, data_size, data_wdata.
REQ-010 SHALL have port dcache_rsp_i, input, dcache_req_o_t, load port response.
  - Fields used: data_gnt, data_rvalid, data_rdata.
REQ-011 SHALL have port restore_valid_o, input to BHT, 1, write strobe.
REQ-012 SHALL have port restore_word_o, output, $clog2(NR_WORDS), word index being written.
REQ-013 SHALL have port restore_data_o, output, 48, 16 entries x {valid, counter[1:0]}.
REQ-014 SHALL have port busy_o, output, 1, restore in progress.
REQ-015 SHALL have port done_o, output, 1, single-cycle completion pulse.

Function
REQ-016 SHALL implement FSM states IDLE, REQ, TAG, WAIT, WRITE, DONE.
REQ-017 SHALL transition IDLE->REQ on start_i, clear word counter to 0, latch base_addr_i[63:3].
REQ-018 SHALL, in REQ, drive data_req=1, address_index=addr[11:0], where addr={base+word,3'b000}; base+word wraps mod 2^61.
REQ-019 SHALL hold data_req and address stable until data_gnt, then go to TAG.
REQ-020 SHALL, in TAG, drive tag_valid=1 and address_tag=addr[55:12] for exactly one cycle, then go to WAIT.
REQ-021 SHALL sample data_rvalid in TAG and WAIT; on rvalid, capture data_rdata and go to WRITE.
REQ-022 SHALL keep one outstanding load at most.
REQ-023 SHALL always drive data_we=0, data_be=8'hFF, data_size=2'b11, data_wdata=0.
REQ-024 SHALL map entry k (0..15) of a captured word as follows:
  - Source: bits [4k+2:4k].
  - Destination: restore_data_o[3k+2:3k], with the bit order {valid, ctr[1:0]}.
  - Bit 4k+3 is ignored.
REQ-025 SHALL, in WRITE, assert restore_valid_o for exactly one cycle with restore_word_o = counter.
REQ-026 SHALL exit WRITE as follows:
  - If counter == NR_WORDS-1: go to DONE.
  - Otherwise: increment counter and go to REQ.
REQ-027 SHALL assert done_o for one cycle in DONE, then return to IDLE.
REQ-028 SHALL assert busy_o in every state except IDLE.
REQ-029 SHALL ignore start_i when not in IDLE.
REQ-030 SHALL handle flush_i in REQ..WRITE as follows:
  - Drive kill_req=1 for that cycle.
  - Suppress restore_valid_o and done_o.
  - Return to IDLE next cycle.
REQ-031 SHALL give flush_i priority over a simultaneous data_gnt, data_rvalid, or start_i.
REQ-032 SHALL treat flush_i in IDLE or DONE as no effect; done_o in DONE still fires.
REQ-033 SHALL drop a late data_rvalid arriving after an abort while in IDLE.

Reset
REQ-034 SHALL, on rst_ni low, immediately enter IDLE with counter 0 and latched base 0.
REQ-035 SHALL, on rst_ni low, drive all outputs 0, including data_req, tag_valid, kill_req, restore_valid_o, busy_o and done_o.
REQ-036 SHALL abandon a reset mid-restore, with no restore_valid_o or done_o emitted afterward.

Verification
REQ-037 Full restore:
  - Stimulus: NR_ENTRIES=32, base=0x8000_1000, gnt and rvalid one cycle later; words 0x0...0765_4321 and 0xF...FFFF.
  - Response: two restore_valid_o pulses with word 0 then 1; addresses 0x...1000 and 0x...1008; done_o one cycle after second write.
REQ-038 Grant stall:
  - Stimulus: data_gnt withheld 5 cycles.
  - Response: data_req and address_index held constant 5 cycles; tag_valid one cycle after gnt only.
REQ-039 Flush during WAIT:
  - Stimulus: flush_i in WAIT.
  - Response: kill_req=1 that cycle; busy_o=0 next cycle; no restore_valid_o and no done_o; subsequent start_i restores from word 0.
REQ-040 Start while busy:
  - Stimulus: start_i pulsed during REQ with a different base_addr_i.
  - Response: ignored; addresses continue from the original base.
REQ-041 Reset mid-restore:
  - Stimulus: rst_ni low during TAG.
  - Response: all outputs 0 asynchronously; IDLE after release.
REQ-042 Address wrap:
  - Stimulus: base=0xFFFF_FFFF_FFFF_FFF8, NR_WORDS=2.
  - Response: second address = 0x0; address_tag=0.
